// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type codes, word width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Frame FSM states, common to the receive and transmit paths.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Parity type codes as carried on the ParType pins.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Data word width in bits from its log2.
    function automatic int data_width(input int log2_width);
        return 1 << log2_width;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Serial line front end: 2-flop synchroniser, per-bit edge counter, 2-of-3 majority vote.
// Latency: 2 cycles line-to-logic; bit value ready at edge count OVERSAMPLE/2+1.
// Backpressure: none; bit_ready is a one-cycle strobe that must be consumed when raised.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 8,
    parameter int CW         = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_n,
    input  logic          rx_in,
    input  logic          run,
    output logic          line,
    output logic [CW-1:0] edge_cnt,
    output logic          bit_ready,
    output logic          bit_val
);

    localparam int MID = OVERSAMPLE / 2;

    logic sync1;
    logic sync2;
    logic samp_a;
    logic samp_b;

    // Two-stage synchroniser; both stages reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else if (!clr_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    // Edge counter: free-runs modulo OVERSAMPLE while a frame is active, held at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (!clr_n || !run) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // Capture the first two of the three mid-bit samples; the third is the live line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (!clr_n) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (edge_cnt == CW'(MID - 1)) samp_a <= sync2;
            if (edge_cnt == CW'(MID))     samp_b <= sync2;
        end
    end

    assign line      = sync2;
    assign bit_ready = (edge_cnt == CW'(MID + 1));
    assign bit_val   = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start detect, LSB-first deserialise, optional parity, stop check.
// Latency: word/error strobes one cycle after the stop-bit majority decision.
// Backpressure: none; strobes are single-cycle and Rx_Pdata holds the last good word.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DataWIDTH  = 3,
    parameter int OVERSAMPLE = 8
) (
    input  logic                            Rx_CLK,
    input  logic                            Rx_RST_ASYN,
    input  logic                            Rx_RST_SYN,
    input  logic                            Rx_In,
    input  logic                            Rx_ParityEn,
    input  logic                            Rx_ParType,
    output logic [data_width(DataWIDTH)-1:0] Rx_Pdata,
    output logic                            Rx_DataValid,
    output logic                            Rx_ParErr,
    output logic                            Rx_StopErr,
    output logic                            Rx_Busy
);

    localparam int W  = data_width(DataWIDTH);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DataWIDTH > 0) ? DataWIDTH : 1;

    uart_state_t   state;
    uart_state_t   next_state;
    logic          line;
    logic [CW-1:0] edge_cnt;
    logic          bit_ready;
    logic          bit_val;
    logic          bit_end;
    logic          run;
    logic [W-1:0]  shreg;
    logic [IW-1:0] bit_idx;
    logic          par_en_l;
    logic          par_type_l;
    logic          par_bad;
    logic          frame_ok;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE),
        .CW        (CW)
    ) u_sampler (
        .clk      (Rx_CLK),
        .rst_n    (Rx_RST_ASYN),
        .clr_n    (Rx_RST_SYN),
        .rx_in    (Rx_In),
        .run      (run),
        .line     (line),
        .edge_cnt (edge_cnt),
        .bit_ready(bit_ready),
        .bit_val  (bit_val)
    );

    assign bit_end  = (edge_cnt == CW'(OVERSAMPLE - 1));
    assign frame_ok = bit_val & ~(par_en_l & par_bad);
    assign Rx_Busy  = (state != IDLE);

    // State register.
    always_ff @(posedge Rx_CLK or negedge Rx_RST_ASYN) begin
        if (!Rx_RST_ASYN) begin
            state <= IDLE;
        end else if (!Rx_RST_SYN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the edge counter runs whenever the next state is not IDLE,
    // so the cycle that first sees the low line becomes count 0 of the start bit.
    always_comb begin
        next_state = state;
        run        = 1'b0;
        case (state)
            IDLE:    if (!line) next_state = START;
            START: begin
                if (bit_ready && bit_val) next_state = IDLE;   // start bit was a glitch
                else if (bit_end)         next_state = DATA;
            end
            DATA:    if (bit_end && bit_idx == IW'(W - 1))
                         next_state = par_en_l ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (bit_ready) next_state = IDLE;         // leave early for back-to-back frames
            default: next_state = IDLE;
        endcase
        run = (next_state != IDLE);
    end

    // Frame datapath: config latch, shift register, parity check and registered outputs.
    always_ff @(posedge Rx_CLK or negedge Rx_RST_ASYN) begin
        if (!Rx_RST_ASYN) begin
            shreg        <= '0;
            bit_idx      <= '0;
            par_en_l     <= 1'b0;
            par_type_l   <= PAR_EVEN;
            par_bad      <= 1'b0;
            Rx_Pdata     <= '0;
            Rx_DataValid <= 1'b0;
            Rx_ParErr    <= 1'b0;
            Rx_StopErr   <= 1'b0;
        end else if (!Rx_RST_SYN) begin
            shreg        <= '0;
            bit_idx      <= '0;
            par_en_l     <= 1'b0;
            par_type_l   <= PAR_EVEN;
            par_bad      <= 1'b0;
            Rx_Pdata     <= '0;
            Rx_DataValid <= 1'b0;
            Rx_ParErr    <= 1'b0;
            Rx_StopErr   <= 1'b0;
        end else begin
            Rx_DataValid <= 1'b0;
            Rx_ParErr    <= 1'b0;
            Rx_StopErr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!line) begin
                        par_en_l   <= Rx_ParityEn;
                        par_type_l <= Rx_ParType;
                        par_bad    <= 1'b0;
                        bit_idx    <= '0;
                    end
                end
                DATA: begin
                    if (bit_ready) shreg <= {bit_val, shreg[W-1:1]};
                    if (bit_end)   bit_idx <= bit_idx + 1'b1;
                end
                PARITY: begin
                    if (bit_ready)
                        par_bad <= bit_val ^ (^shreg) ^ (par_type_l == PAR_ODD);
                end
                STOP: begin
                    if (bit_ready) begin
                        Rx_StopErr   <= ~bit_val;
                        Rx_ParErr    <= par_en_l & par_bad;
                        Rx_DataValid <= frame_ok;
                        if (frame_ok) Rx_Pdata <= shreg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver (8-bit words, 8x oversampling).
// Frames are described at bit level; a frame-level model predicts each strobe and its cycle.
// Every strobe seen on the outputs is logged and matched against the prediction queue.
module tb_uart_receiver;

    localparam int W = 8;
    localparam int O = 8;

    typedef struct packed {
        logic [31:0]  cyc;
        logic         v;
        logic         pe;
        logic         se;
        logic [W-1:0] pd;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst_asyn;
    logic         rst_syn;
    logic         rx_in;
    logic         par_en;
    logic         par_type;
    logic [W-1:0] pdata;
    logic         valid;
    logic         perr;
    logic         serr;
    logic         busy;

    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] model_pd = '0;
    ev_t          exp_q[$];
    ev_t          got_q[$];

    uart_receiver #(.DataWIDTH(3), .OVERSAMPLE(O)) dut (
        .Rx_CLK      (clk),
        .Rx_RST_ASYN (rst_asyn),
        .Rx_RST_SYN  (rst_syn),
        .Rx_In       (rx_in),
        .Rx_ParityEn (par_en),
        .Rx_ParType  (par_type),
        .Rx_Pdata    (pdata),
        .Rx_DataValid(valid),
        .Rx_ParErr   (perr),
        .Rx_StopErr  (serr),
        .Rx_Busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe cycle together with the word visible at that time.
    always @(negedge clk) begin
        if (valid || perr || serr)
            got_q.push_back(ev_t'({32'(cyc), valid, perr, serr, pdata}));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one frame starting in the current cycle and queue the predicted outcome.
    task automatic send_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                              input logic par_flip, input logic stop, input logic glitch);
        logic [W+2:0] bits;
        int           nb;
        int           f;
        int           t;
        logic         good_par;
        logic         mism;
        logic         v;
        bits     = '0;
        good_par = logic'($countones(d) % 2) ^ pt;   // bit that makes the total even/odd
        bits[0]  = 1'b0;
        for (int i = 0; i < W; i++) bits[1 + i] = d[i];
        nb = W + 1;
        if (pe) begin
            bits[nb] = good_par ^ par_flip;
            nb++;
        end
        bits[nb] = stop;
        nb++;

        par_en   = pe;
        par_type = pt;
        f        = cyc;
        t        = f + 2;
        mism     = pe && par_flip;
        v        = stop && !mism;
        if (v) model_pd = d;
        exp_q.push_back(ev_t'({32'(t + (nb - 1) * O + O / 2 + 2), v, mism, !stop, model_pd}));

        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < O; k++) begin
                rx_in = bits[b] ^ (glitch && b >= 1 && b <= W && k == O / 2);
                if (b == 3 && k == 0) begin
                    par_en   = 1'($urandom);
                    par_type = 1'($urandom);
                end
                tick(1);
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_cycle"}, 64'(got_q[i].cyc), 64'(exp_q[i].cyc));
            chk({tag, "_flags_data"}, 64'({got_q[i].v, got_q[i].pe, got_q[i].se, got_q[i].pd}),
                64'({exp_q[i].v, exp_q[i].pe, exp_q[i].se, exp_q[i].pd}));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int f;
        logic [W-1:0] d;
        logic pe;
        logic pt;
        logic flip;
        logic stop;
        logic gl;

        // Reset state
        rst_asyn = 1'b0;
        rst_syn  = 1'b1;
        rx_in    = 1'b1;
        par_en   = 1'b0;
        par_type = 1'b0;
        tick(3);
        chk("rst_pdata", 64'(pdata), 64'(0));
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_parerr", 64'(perr), 64'(0));
        chk("rst_stoperr", 64'(serr), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_asyn = 1'b1;
        tick(4);

        // Plain frame, no parity
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(12);
        check_events("a5_noparity");

        // Even parity, correct then wrong parity bit
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(12);
        check_events("3c_even_ok");
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(12);
        check_events("3c_even_bad");

        // Stop error, then line high 8 clocks and a clean frame
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(8);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(12);
        check_events("55_stoperr_0f");

        // Short low pulse: rejected by the start-bit majority
        f = cyc;
        rx_in = 1'b0;
        tick(3);
        rx_in = 1'b1;
        tick(2);
        chk("glitch_busy_T+3", 64'(busy), 64'(1));
        tick(3);
        chk("glitch_busy_T+6", 64'(busy), 64'(0));
        tick(10);
        check_events("start_glitch");

        // Back-to-back frames, next start exactly at stop-bit end
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(12);
        check_events("back_to_back");

        // One-clock glitch at every data mid-sample, odd parity, back-to-back
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(12);
        check_events("midsample_glitch");

        // Async reset in the middle of DATA of 0xFF
        par_en = 1'b0;
        rx_in  = 1'b0;
        tick(O);
        rx_in = 1'b1;
        tick(20);
        chk("arst_busy_before", 64'(busy), 64'(1));
        #2 rst_asyn = 1'b0;
        #1;
        chk("arst_pdata", 64'(pdata), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_strobes", 64'({valid, perr, serr}), 64'(0));
        @(posedge clk);
        #1 rst_asyn = 1'b1;
        model_pd = '0;
        tick(10);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(12);
        check_events("after_arst");

        // Sync clear in the middle of a frame
        rx_in = 1'b0;
        tick(O);
        rx_in = 1'b1;
        tick(12);
        rst_syn = 1'b0;
        tick(1);
        chk("srst_pdata", 64'(pdata), 64'(0));
        chk("srst_busy", 64'(busy), 64'(0));
        rst_syn = 1'b1;
        model_pd = '0;
        tick(80);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(12);
        check_events("after_srst");

        // Randomised frames with random parity config and error injection
        for (int n = 0; n < 12; n++) begin
            d    = W'($urandom);
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            flip = ($urandom_range(3) == 0);
            stop = ($urandom_range(3) != 0);
            gl   = 1'($urandom);
            send_frame(d, pe, pt, flip, stop, gl);
            tick(12 + $urandom_range(4));
            check_events("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
